// File: rtl/song_tutor_seq.sv
// Loadable song tutor: walks the player through a stored song note by note, flagging wrong keys and timeouts.
// Optional miss counter output err_cnt is enabled by defining SONG_TUTOR_ERRCNT_EN.
module song_tutor_seq #(
  parameter int NOTE_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int NONE_CODE = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NOTE_W-1:0] note,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [ADDR_W:0]   song_len,
  input  logic              start,
  input  logic              strict,
  output logic [NOTE_W-1:0] expect_note,
  output logic [ADDR_W-1:0] pos,
  output logic              busy,
  output logic              miss,
  output logic              done
`ifdef SONG_TUTOR_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NOTE_W-1:0] NONE    = NOTE_W'(NONE_CODE);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_REL, DONE} state_t;

  state_t            state;
  logic [NOTE_W-1:0] mem [DEPTH];
  logic [NOTE_W-1:0] cur_note;
  logic [ADDR_W:0]   len_q;
  logic              strict_q;
  logic              hit;
  logic [TW-1:0]     timer;
  logic              start_ok;
  logic              timeout_hit;
  logic              last_note;
  logic              miss_set;

  assign cur_note    = mem[pos];
  assign start_ok    = start && (song_len != '0);
  assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign last_note   = ({1'b0, pos} == (len_q - (ADDR_W + 1)'(1)));
  assign miss_set    = (state == WAIT_PRESS) &&
                       (((note == NONE) && timeout_hit) ||
                        ((note != NONE) && (note != cur_note)));

  // Song storage is never cleared; it is frozen while a lesson runs.
  always_ff @(posedge CLK) begin
    if (wr_en && !busy)
      mem[wr_addr] <= wr_note;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pos         <= '0;
      expect_note <= NONE;
      busy        <= 1'b0;
      miss        <= 1'b0;
      done        <= 1'b0;
      timer       <= '0;
      hit         <= 1'b0;
    end else begin
      miss        <= miss_set;
      done        <= 1'b0;
      expect_note <= ((state == WAIT_PRESS) || (state == WAIT_REL)) ? cur_note : NONE;
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q    <= (song_len > DEPTH_L) ? DEPTH_L : song_len;
            strict_q <= strict;
            state    <= WAIT_PRESS;
            pos      <= '0;
            busy     <= 1'b1;
            timer    <= '0;
          end
        end
        WAIT_PRESS: begin
          if (note == NONE) begin
            if (timeout_hit) begin
              timer <= '0;
              if (strict_q)
                pos <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            hit   <= (note == cur_note);
            state <= WAIT_REL;
            timer <= '0;
          end
        end
        WAIT_REL: begin
          // Key changes while held are deliberately ignored; only the release matters.
          if (note == NONE) begin
            timer <= '0;
            if (hit && last_note) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pos   <= '0;
            end else begin
              state <= WAIT_PRESS;
              if (hit)
                pos <= pos + ADDR_W'(1);
              else if (strict_q)
                pos <= '0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SONG_TUTOR_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      err_cnt <= '0;
    else if ((state == IDLE) && start_ok)
      err_cnt <= '0;
    else if (miss_set && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_song_tutor_seq.sv
// Bench for song_tutor_seq: directed lessons checked every cycle against a behavioural lesson model.
module tb_song_tutor_seq;
  localparam int TIMEOUT = 8;
  localparam logic [3:0] NONE = 4'd0, C = 4'd1, D = 4'd2, E = 4'd3, F = 4'd4, G = 4'd5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] note = NONE;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_note = '0;
  logic [4:0] song_len = '0;
  logic       start = 1'b0;
  logic       strict = 1'b0;
  logic [3:0] expect_note;
  logic [3:0] pos;
  logic       busy, miss, done;
`ifdef SONG_TUTOR_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_cmp = 0, n_fail = 0;
  int miss_seen = 0, done_seen = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  song_tutor_seq #(.NOTE_W(4), .ADDR_W(4), .NONE_CODE(0), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .note(note), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .song_len(song_len), .start(start), .strict(strict),
    .expect_note(expect_note), .pos(pos), .busy(busy), .miss(miss), .done(done)
`ifdef SONG_TUTOR_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Lesson model: phase 0 idle, 1 awaiting a key, 2 key held, 3 finish pulse.
  logic [3:0] song [16];
  int   phase = 0, m_len = 0, timer = 0, e_pos = 0, e_err = 0;
  bit   m_strict = 0, m_hit = 0, e_busy = 0, e_miss = 0, e_done = 0;
  logic [3:0] e_expect = NONE;

  initial foreach (song[i]) song[i] = '0;

  always @(posedge CLK) begin
    if (RESET) begin
      phase = 0; e_pos = 0; e_busy = 0; e_miss = 0; e_done = 0;
      e_expect = NONE; timer = 0; e_err = 0;
    end else begin
      e_expect = (phase == 1 || phase == 2) ? song[e_pos] : NONE;
      e_miss = 0; e_done = 0;
      if (!e_busy && wr_en) song[wr_addr] = wr_note;
      case (phase)
        0: if (start && song_len != 0) begin
             m_len = (int'(song_len) > 16) ? 16 : int'(song_len);
             m_strict = strict; phase = 1; e_pos = 0; e_busy = 1; timer = 0; e_err = 0;
           end
        1: if (note == NONE) begin
             if (timer == TIMEOUT - 1) begin
               e_miss = 1; timer = 0;
               if (m_strict) e_pos = 0;
             end else timer++;
           end else begin
             m_hit = (note == song[e_pos]); e_miss = !m_hit; phase = 2; timer = 0;
           end
        2: if (note == NONE) begin
             timer = 0;
             if (m_hit && e_pos == m_len - 1) begin
               phase = 3; e_done = 1; e_busy = 0; e_pos = 0;
             end else begin
               phase = 1;
               if (m_hit) e_pos++;
               else if (m_strict) e_pos = 0;
             end
           end
        default: phase = 0;
      endcase
      if (e_miss && e_err < 255) e_err++;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("pos", 32'(pos), 32'(e_pos));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("miss", 32'(miss), 32'(e_miss));
      chk("done", 32'(done), 32'(e_done));
      chk("expect_note", 32'(expect_note), 32'(e_expect));
`ifdef SONG_TUTOR_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(e_err));
`endif
      if (miss === 1'b1) miss_seen++;
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic settle_clear();
    #2; miss_seen = 0; done_seen = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] n);
    wr_en = 1'b1; wr_addr = a; wr_note = n;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic begin_lesson(input logic [4:0] len, input logic st);
    start = 1'b1; song_len = len; strict = st;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] n, input int hold, input int rel);
    note = n; cyc(hold);
    note = NONE; cyc(rel);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1; cyc(1); RESET = 1'b0;
  endtask

  task automatic load_eefg();
    write(0, E); write(1, E); write(2, F); write(3, G);
  endtask

  initial begin
    cyc(3);
    RESET = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("rst_pos", 32'(pos), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_expect", 32'(expect_note), 32'(NONE));
    chk("rst_pulses", 32'(miss | done), 0);
    cyc(1);

    // 1: plain lesson E,E,F,G
    load_eefg();
    begin_lesson(5'd4, 1'b0);
    settle_clear();
    press(E, 2, 2);
    #2; chk("t1_pos1", 32'(pos), 1);
    press(E, 2, 2); press(F, 2, 2); press(G, 2, 2);
    #2;
    chk("t1_done", 32'(done_seen), 1);
    chk("t1_miss", 32'(miss_seen), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_pos", 32'(pos), 0);

    // 2: non-strict wrong key; strict input toggled mid-lesson has no effect
    begin_lesson(5'd4, 1'b0);
    settle_clear();
    strict = 1'b1;
    cyc(1);
    #2; chk("t2_expect0", 32'(expect_note), 32'(E));
    press(E, 2, 2); press(E, 2, 2);
    press(D, 2, 2);
    #2;
    chk("t2_miss", 32'(miss_seen), 1);
    chk("t2_pos_hold", 32'(pos), 2);
`ifdef SONG_TUTOR_ERRCNT_EN
    chk("t2_errcnt", 32'(err_cnt), 1);
`endif
    press(F, 2, 2);
    #2; chk("t2_pos3", 32'(pos), 3);
    press(G, 2, 2);
    #2; chk("t2_done", 32'(done_seen), 1);
    strict = 1'b0;

    // 3: strict, long wrong hold at last note
    begin_lesson(5'd4, 1'b1);
    settle_clear();
    press(E, 2, 2); press(E, 2, 2); press(F, 2, 2);
    #2; chk("t3_pos3", 32'(pos), 3);
    press(C, 10, 2);
    #2;
    chk("t3_one_miss", 32'(miss_seen), 1);
    chk("t3_pos0", 32'(pos), 0);
    press(E, 2, 2); press(E, 2, 2); press(F, 2, 2); press(G, 2, 2);
    #2; chk("t3_done", 32'(done_seen), 1);

    // 4: timeouts, non-strict then strict
    begin_lesson(5'd4, 1'b0);
    settle_clear();
    cyc(19);
    #2;
    chk("t4_ns_miss0", 32'(miss_seen), 2);
    chk("t4_ns_pos0", 32'(pos), 0);
    press(E, 2, 2);
    settle_clear();
    cyc(20);
    #2;
    chk("t4_ns_miss1", 32'(miss_seen), 2);
    chk("t4_ns_pos1", 32'(pos), 1);
    pulse_reset();
    begin_lesson(5'd4, 1'b1);
    press(E, 2, 2);
    settle_clear();
    cyc(8);
    #2;
    chk("t4_s_miss", 32'(miss_seen), 1);
    chk("t4_s_pos", 32'(pos), 0);
    pulse_reset();

    // 5: zero length ignored; oversize length clamps to 16
    begin_lesson(5'd0, 1'b0);
    cyc(2);
    #2; chk("t5_len0_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++) write(4'(i), 4'((i % 5) + 1));
    begin_lesson(5'd20, 1'b0);
    settle_clear();
    for (int i = 0; i < 16; i++) press(4'((i % 5) + 1), 1, 1);
    #2;
    chk("t5_done16", 32'(done_seen), 1);
    chk("t5_miss", 32'(miss_seen), 0);
    chk("t5_busy", 32'(busy), 0);

    // 6: write during lesson ignored; reset mid-lesson
    load_eefg();
    begin_lesson(5'd4, 1'b0);
    settle_clear();
    write(0, G);
    press(E, 2, 2);
    #2;
    chk("t6_wr_ignored", 32'(miss_seen), 0);
    chk("t6_pos1", 32'(pos), 1);
    note = E; cyc(1);
    RESET = 1'b1; cyc(1); RESET = 1'b0;
    note = NONE; cyc(2);
    #2;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_pos", 32'(pos), 0);
    chk("t6_expect", 32'(expect_note), 32'(NONE));
    chk("t6_no_pulses", 32'(miss_seen + done_seen), 0);
`ifdef SONG_TUTOR_ERRCNT_EN
    chk("t6_errcnt", 32'(err_cnt), 0);
`endif
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
